mul_seq_ctrl: RTL and testbench

- Multi-cycle RV32M multiply sequencer for the execute stage.
- Handles MUL, MULH, MULHSU and MULHU.
- Time-shares one internal unsigned 16x16 multiplier over four partial-product cycles to save DSP/LUT area.
- Handles operand sign by magnitude-and-correct.
- Talks to the pipeline over valid/ready request and response channels, with a flush input for squashed instructions.

---
 rtl/mul_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - multi-cycle RV32M multiply sequencer (one shared 16x16 multiplier)
module mul_seq_ctrl #(
   parameter bit BYPASS_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  funct3,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] y,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_P0   = 3'd1,
      S_P1   = 3'd2,
      S_P2   = 3'd3,
      S_P3   = 3'd4,
      S_FIX  = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ma_q, ma_d;
   logic [31:0] mb_q, mb_d;
   logic        neg_q, neg_d;
   logic        hi_q, hi_d;
   logic [63:0] acc_q, acc_d;

   logic        accept;
   logic        zero_op;
   logic        sa, sb;
   logic [15:0] mul_a, mul_b;
   logic [31:0] prod;
   logic        unused_funct3;

   assign unused_funct3 = funct3[2];
   assign accept  = req_valid && req_ready;
   assign zero_op = (a == 32'd0) || (b == 32'd0);
   assign sa      = a[31] && (funct3[1:0] != 2'b11);
   assign sb      = b[31] && !funct3[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ma_q    <= 32'd0;
         mb_q    <= 32'd0;
         neg_q   <= 1'b0;
         hi_q    <= 1'b0;
         acc_q   <= 64'd0;
      end else begin
         state_q <= state_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         acc_q   <= acc_d;
      end
   end

   // Bypassed requests still pass through FIX so the response lands one cycle after accept.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (accept) state_d = (BYPASS_ZERO && zero_op) ? S_FIX : S_P0;
            S_P0:    state_d = S_P1;
            S_P1:    state_d = S_P2;
            S_P2:    state_d = S_P3;
            S_P3:    state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mul_a = 16'd0;
      mul_b = 16'd0;
      case (state_q)
         S_P0:    begin mul_a = ma_q[15:0];  mul_b = mb_q[15:0];  end
         S_P1:    begin mul_a = ma_q[15:0];  mul_b = mb_q[31:16]; end
         S_P2:    begin mul_a = ma_q[31:16]; mul_b = mb_q[15:0];  end
         S_P3:    begin mul_a = ma_q[31:16]; mul_b = mb_q[31:16]; end
         default: begin mul_a = 16'd0;       mul_b = 16'd0;       end
      endcase
   end

   assign prod = {16'd0, mul_a} * {16'd0, mul_b};

   always_comb begin
      ma_d  = ma_q;
      mb_d  = mb_q;
      neg_d = neg_q;
      hi_d  = hi_q;
      acc_d = acc_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               ma_d  = sa ? (~a + 32'd1) : a;
               mb_d  = sb ? (~b + 32'd1) : b;
               neg_d = sa ^ sb;
               hi_d  = |funct3[1:0];
               if (BYPASS_ZERO && zero_op) acc_d = 64'd0;
            end
         end
         S_P0:    acc_d = {32'd0, prod};
         S_P1,
         S_P2:    acc_d = acc_q + ({32'd0, prod} << 16);
         S_P3:    acc_d = acc_q + {prod, 32'd0};
         S_FIX:   acc_d = neg_q ? (~acc_q + 64'd1) : acc_q;
         default: acc_d = acc_q;
      endcase
   end

   always_comb begin
      req_ready = (state_q == S_IDLE) && !flush;
      rsp_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      y         = 32'd0;
      if (state_q == S_DONE) y = hi_q ? acc_q[63:32] : acc_q[31:0];
   end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed vector bench for mul_seq_ctrl
module tb_mul_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [2:0]  f3;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] y;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul_seq_ctrl #(.BYPASS_ZERO(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .a         (a_i),
      .b         (b_i),
      .funct3    (f3),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .y         (y),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f;
      logic [31:0] exp_y;
      int          exp_lat;
      int          exp_busy;
      string       name;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input logic [2:0] f,
                         input logic [31:0] ey, input int elat, input int ebusy, input string nm);
      int lat;
      int bc;
      @(negedge clk);
      a_i = ai; b_i = bi; f3 = f; req_valid = 1'b1; rsp_ready = 1'b1;
      chk({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      bc  = 0;
      while (!rsp_valid && lat < 20) begin
         if (busy) bc++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy) bc++;
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_y"}, y, ey);
      @(posedge clk); #1;
      if (busy) bc++;
      chk({nm, "_busy_cycles"}, bc, ebusy);
      chk({nm, "_rsp_valid_after"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   vec_t vecs[$];
   int   seen_rsp;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; a_i = 32'd0; b_i = 32'd0; f3 = 3'b000;
      flush = 1'b0; rsp_ready = 1'b0;

      vecs.push_back('{32'h00000007, 32'hFFFFFFFD, 3'b000, 32'hFFFFFFEB, 5, 6, "mul_signed"});
      vecs.push_back('{32'h80000000, 32'h80000000, 3'b001, 32'h40000000, 5, 6, "mulh_extreme"});
      vecs.push_back('{32'h80000000, 32'h80000000, 3'b000, 32'h00000000, 5, 6, "mul_extreme"});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFF, 5, 6, "mulhsu_ones"});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'hFFFFFFFE, 5, 6, "mulhu_ones"});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 32'hFFFFFFFE, 5, 6, "f3_111"});
      vecs.push_back('{32'hFFFFFFFE, 32'h00000003, 3'b001, 32'hFFFFFFFF, 5, 6, "mulh_neg"});
      vecs.push_back('{32'hFFFFFFFE, 32'h80000000, 3'b010, 32'hFFFFFFFF, 5, 6, "mulhsu_mix"});
      vecs.push_back('{32'h00010000, 32'h00010000, 3'b011, 32'h00000001, 5, 6, "mulhu_2p32"});
      vecs.push_back('{32'h00000003, 32'h00000005, 3'b000, 32'h0000000F, 5, 6, "mul_3x5"});
      vecs.push_back('{32'h00000000, 32'h12345678, 3'b001, 32'h00000000, 1, 2, "bypass_a0"});
      vecs.push_back('{32'h0000ABCD, 32'h00000000, 3'b000, 32'h00000000, 1, 2, "bypass_b0"});

      #2;
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_y", y, 32'd0);
      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk); rst_n = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].exp_y,
                vecs[i].exp_lat, vecs[i].exp_busy, vecs[i].name);

      // Zero bypass held under back-pressure; a second request must wait.
      @(negedge clk);
      a_i = 32'd0; b_i = 32'h12345678; f3 = 3'b001; req_valid = 1'b1; rsp_ready = 1'b0;
      @(posedge clk); #1;
      a_i = 32'd3; b_i = 32'd5; f3 = 3'b000;
      chk("bp_not_yet_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_y", y, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_hold_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("bp_hold_y_%0d", k), y, 32'd0);
         chk($sformatf("bp_hold_ready_%0d", k), {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
      chk("bp_release_busy", {31'd0, busy}, 32'd0);

      // Flush in P2 of a MULHU.
      @(negedge clk);
      a_i = 32'h00010000; b_i = 32'h00010000; f3 = 3'b011; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("flush_busy_in_p2", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      chk("flush_busy_drop", {31'd0, busy}, 32'd0);
      a_i = 32'd9; b_i = 32'd9; f3 = 3'b000; req_valid = 1'b1;
      seen_rsp = 0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("flush_req_ready_%0d", k), {31'd0, req_ready}, 32'd0);
         @(posedge clk); #1;
         if (rsp_valid) seen_rsp++;
         chk($sformatf("flush_no_accept_%0d", k), {31'd0, busy}, 32'd0);
      end
      chk("flush_no_rsp", seen_rsp, 0);
      flush = 1'b0; req_valid = 1'b0;
      run_op(32'd3, 32'd5, 3'b000, 32'h0000000F, 5, 6, "after_flush");

      // Asynchronous reset mid-P1.
      @(negedge clk);
      a_i = 32'd7; b_i = 32'd9; f3 = 3'b000; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_y", y, 32'd0);
      chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk); rst_n = 1'b1;
      run_op(32'd2, 32'd3, 3'b000, 32'h00000006, 5, 6, "after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
